// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// master: requester side (drives en/req/done); slave: the arbiter.
interface rr_arbiter_8_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a bounded hold time.
// One owner at a time and no preemption. Every grant is followed by a dead
// IDLE cycle. The scan pointer moves past the last owner on each release.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_8_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t     state_q, state_n;
    logic [7:0] gnt_q, gnt_n;
    logic [2:0] idx_q, idx_n;
    logic       valid_q, valid_n;
    logic       timeout_q, timeout_n;
    logic [2:0] ptr_q, ptr_n;
    logic [7:0] cnt_q, cnt_n;
    // Set one edge after reset release so the first grant cannot land on that edge.
    logic       arm_q;

    logic [2:0] pick_idx;
    logic [2:0] cand;
    logic       pick_found;
    logic       at_limit;
    logic       owner_req;
    logic       release_now;
    logic       forced;

    // First asserted request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        pick_idx   = ptr_q;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!pick_found && bus.req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Release conditions; timeout only when the hold limit is the sole cause.
    always_comb begin
        at_limit    = (cnt_q == HOLD_LIMIT);
        owner_req   = bus.req[idx_q];
        release_now = bus.done || !owner_req || !bus.en || at_limit;
        forced      = at_limit && !bus.done && owner_req && bus.en;
    end

    // Next-state and registered-output values.
    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        idx_n     = idx_q;
        valid_n   = valid_q;
        timeout_n = 1'b0;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_n   = '0;
                valid_n = 1'b0;
                if (arm_q && bus.en && pick_found) begin
                    state_n = GRANT;
                    idx_n   = pick_idx;
                    gnt_n   = 8'b1 << pick_idx;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    valid_n   = 1'b0;
                    ptr_n     = idx_q + 3'd1;
                    timeout_n = forced;
                end else begin
                    cnt_n = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register with asynchronous clear of every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            idx_q     <= idx_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
            ptr_q     <= ptr_n;
            cnt_q     <= cnt_n;
            arm_q     <= 1'b1;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one grant is held (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, sole clock, with all state updating on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1, arbiter enable.
REQ-005 SHALL have port req, input, 8, request lines, where bit i is requester i.
REQ-006 SHALL have port done, input, 1, a release pulse from the current owner.
REQ-007 SHALL have port gnt, output, 8, one-hot grant (registered).
REQ-008 SHALL have port gnt_idx, output, 3, binary index of the owner (registered).
REQ-009 SHALL have port gnt_valid, output, 1, high exactly when gnt is non-zero.
REQ-010 SHALL have port timeout, output, 1, a one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-012 IDLE -> GRANT SHALL occur when en=1 and req!=0.
- Owner: first set req bit found scanning upward from pointer ptr, wrapping 7->0.
- Grant registered: gnt/gnt_idx/gnt_valid are valid on the cycle after the request is sampled.
REQ-013 gnt SHALL always be the one-hot decode of gnt_idx while gnt_valid=1, and SHALL be 8'h00 otherwise.
REQ-014 GRANT -> IDLE SHALL occur on any of these release conditions:
- done=1;
- req[gnt_idx]=0;
- en=0;
- hold counter reaches MAX_HOLD-1.
REQ-015 On release, gnt SHALL be 8'h00 in the next cycle.
REQ-016 Each grant SHALL be followed by at least one IDLE cycle (dead cycle), so a re-grant appears earliest 2 cycles after release.
REQ-017 On every release, ptr SHALL update to (gnt_idx+1) mod 8 (3-bit wrap), so the last owner has lowest priority.
REQ-018 ptr SHALL be unchanged while in IDLE with no grant.
REQ-019 The hold counter SHALL:
- clear to 0 on entry to GRANT;
- increment each GRANT cycle;
- saturate, never wrapping.
REQ-020 timeout SHALL pulse for one cycle, coincident with the first gnt=0 cycle, only when release is due solely to the counter.
REQ-021 If done or req drop coincides with counter=MAX_HOLD-1, the release SHALL be normal and timeout SHALL stay 0.
REQ-022 When en=0 in IDLE, no grant SHALL be issued.
REQ-023 ptr SHALL be retained across en low periods.
REQ-024 done SHALL be ignored in IDLE.
REQ-025 Requests arriving during GRANT SHALL be evaluated only after return to IDLE (no preemption).
REQ-026 With req=8'hFF held and done pulsed each grant, owners SHALL cycle 0,1,2,...,7,0 given ptr=0 initially.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force:
- state=IDLE;
- gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0;
- ptr=3'd0;
- hold counter=0.
REQ-028 Reset asserted mid-grant SHALL drop the grant asynchronously, and no timeout pulse SHALL be generated.
REQ-029 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-030 Single request: after reset, en=1, req=8'h10 held, done pulsed at grant cycle 3 -> gnt=8'h10 and gnt_idx=4 one cycle after req; gnt=0 after done; ptr=5.
REQ-031 Round robin: req=8'hFF held, done pulsed every grant -> gnt_idx sequence 0,1,...,7,0 with one dead cycle between grants.
REQ-032 Timeout: req=8'h01 held, done=0, MAX_HOLD=16 -> gnt=8'h01 for exactly 16 cycles, then timeout=1 for 1 cycle with gnt=0, then re-grant to 0 after the dead cycle.
REQ-033 Wrap and skip: ptr=7 (after owner 6), req=8'h05 -> owner 0, then 2.
REQ-034 Priority order: req=8'h81 with ptr=1 -> owner 7 before owner 0.
REQ-035 Async reset mid-grant: rst_n pulled low between clock edges while gnt=8'h08 -> gnt=0 without a clock edge; ptr=0; timeout stays 0.
REQ-036 Enable drop: en=0 during a grant -> release next cycle, no further grant while en=0, ptr preserved.
